// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD matrix-multiply sequencer.
package simd_pkg;

  localparam int DATA_W = 32;
  localparam int N_DEF  = 16;

  typedef logic [DATA_W-1:0] word_t;
  typedef word_t [N_DEF-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ_A = 3'd1,
    REQ_B = 3'd2,
    MUL   = 3'd3,
    SUM   = 3'd4,
    OUT   = 3'd5,
    DONE  = 3'd6
  } seq_state_e;

endpackage

// File: rtl/simd_dot_n.sv
// Two-stage N-lane dot product: registered lane products, then a registered
// adder tree. All arithmetic wraps modulo 2^32.
module simd_dot_n
  import simd_pkg::*;
#(
  parameter int N = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             mul_en,
  input  logic             sum_en,
  input  word_t [N-1:0]    row_a,
  input  word_t [N-1:0]    row_b,
  output word_t            sum
);

  word_t [N-1:0] prod_r;
  word_t         sum_r;

  // Balanced binary tree: leaves at N..2N-1, root at index 1.
  function automatic word_t tree_sum(input word_t [N-1:0] v);
    word_t node [2*N];
    for (int k = 0; k < N; k++) begin
      node[N+k] = v[k];
    end
    for (int n = N - 1; n >= 1; n--) begin
      node[n] = node[2*n] + node[2*n+1];
    end
    return node[1];
  endfunction

  // Lane product stage, low 32 bits only.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      prod_r <= '0;
    end else if (mul_en) begin
      for (int k = 0; k < N; k++) begin
        prod_r[k] <= row_a[k] * row_b[k];
      end
    end else begin
      prod_r <= prod_r;
    end
  end

  // Reduction stage.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      sum_r <= '0;
    end else if (sum_en) begin
      sum_r <= tree_sum(prod_r);
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;

endmodule

// File: rtl/simd_matmul_seq.sv
// Sequencer for C = A x B^T: walks the register file row by row, feeds the
// dot-product stage and streams each C[i][j] out over valid/ready.
module simd_matmul_seq
  import simd_pkg::*;
#(
  parameter int N         = 16,
  parameter int FETCH_LAT = 1
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  input  logic                        START,
  input  logic [N-1:0][DATA_W-1:0]    MAT_IN,
  output logic [$clog2(N)-1:0]        SEQ_A,
  output logic [$clog2(N)-1:0]        SEQ_B,
  output logic                        MATAB_MUX,
  output logic [DATA_W-1:0]           RES_DATA,
  output logic [$clog2(N)-1:0]        RES_ROW,
  output logic [$clog2(N)-1:0]        RES_COL,
  output logic                        RES_VALID,
  input  logic                        RES_READY,
  output logic                        BUSY,
  output logic                        DONE
);

  localparam int IDX_W  = $clog2(N);
  localparam int FCNT_W = 3;
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(N - 1);
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FETCH_LAT - 1);

  seq_state_e                 state_r, state_next_s;
  logic [IDX_W-1:0]           i_r, j_r, i_next_s, j_next_s;
  logic [FCNT_W-1:0]          fcnt_r, fcnt_next_s;
  logic [N-1:0][DATA_W-1:0]   row_a_r, row_b_r;
  logic                       cap_a_s, cap_b_s, mul_en_s, sum_en_s, handshake_s;

  logic [IDX_W-1:0] seq_a_r, seq_b_r, row_r, col_r;
  logic [IDX_W-1:0] seq_a_s, seq_b_s, row_s, col_s;
  logic             mux_r, valid_r, busy_r, done_r;
  logic             mux_s, valid_s, busy_s, done_s;

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_r <= IDLE;
      i_r     <= '0;
      j_r     <= '0;
      fcnt_r  <= '0;
      seq_a_r <= '0;
      seq_b_r <= '0;
      row_r   <= '0;
      col_r   <= '0;
      mux_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      i_r     <= i_next_s;
      j_r     <= j_next_s;
      fcnt_r  <= fcnt_next_s;
      seq_a_r <= seq_a_s;
      seq_b_r <= seq_b_s;
      row_r   <= row_s;
      col_r   <= col_s;
      mux_r   <= mux_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Row latches; MAT_IN is sampled on the edge closing the last fetch cycle.
  always_ff @(posedge CLK) begin
    if (RSTN) begin
      row_a_r <= '0;
      row_b_r <= '0;
    end else begin
      if (cap_a_s) row_a_r <= MAT_IN;
      else         row_a_r <= row_a_r;
      if (cap_b_s) row_b_r <= MAT_IN;
      else         row_b_r <= row_b_r;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_next_s = state_r;
    i_next_s     = i_r;
    j_next_s     = j_r;
    fcnt_next_s  = fcnt_r;
    cap_a_s      = 1'b0;
    cap_b_s      = 1'b0;
    mul_en_s     = 1'b0;
    sum_en_s     = 1'b0;
    handshake_s  = valid_r & RES_READY;
    case (state_r)
      IDLE: begin
        if (START) state_next_s = REQ_A;
        else       state_next_s = IDLE;
      end
      REQ_A: begin
        if (fcnt_r == FCNT_LAST) begin
          cap_a_s      = 1'b1;
          fcnt_next_s  = '0;
          state_next_s = REQ_B;
        end else begin
          fcnt_next_s  = fcnt_r + 3'd1;
        end
      end
      REQ_B: begin
        if (fcnt_r == FCNT_LAST) begin
          cap_b_s      = 1'b1;
          fcnt_next_s  = '0;
          state_next_s = MUL;
        end else begin
          fcnt_next_s  = fcnt_r + 3'd1;
        end
      end
      MUL: begin
        mul_en_s     = 1'b1;
        state_next_s = SUM;
      end
      SUM: begin
        sum_en_s     = 1'b1;
        state_next_s = OUT;
      end
      OUT: begin
        // rowA stays latched across a row, so only B is refetched for j+1.
        if (handshake_s) begin
          if (j_r != IDX_MAX) begin
            j_next_s     = j_r + IDX_W'(1);
            state_next_s = REQ_B;
          end else if (i_r != IDX_MAX) begin
            j_next_s     = '0;
            i_next_s     = i_r + IDX_W'(1);
            state_next_s = REQ_A;
          end else begin
            state_next_s = simd_pkg::DONE;
          end
        end else begin
          state_next_s = OUT;
        end
      end
      simd_pkg::DONE: begin
        i_next_s     = '0;
        j_next_s     = '0;
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flops line up with it.
  always_comb begin
    seq_a_s = seq_a_r;
    seq_b_s = seq_b_r;
    row_s   = row_r;
    col_s   = col_r;
    if (state_next_s == REQ_A) seq_a_s = i_next_s;
    else                       seq_a_s = seq_a_r;
    if (state_next_s == REQ_B) seq_b_s = j_next_s;
    else                       seq_b_s = seq_b_r;
    mux_s   = (state_next_s == REQ_A);
    valid_s = (state_next_s == OUT);
    busy_s  = (state_next_s != IDLE);
    done_s  = (state_next_s == simd_pkg::DONE);
    if (valid_s) begin
      row_s = i_next_s;
      col_s = j_next_s;
    end else begin
      row_s = row_r;
      col_s = col_r;
    end
  end

  simd_dot_n #(.N(N)) u_dot (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .mul_en (mul_en_s),
    .sum_en (sum_en_s),
    .row_a  (row_a_r),
    .row_b  (row_b_r),
    .sum    (RES_DATA)
  );

  assign SEQ_A     = seq_a_r;
  assign SEQ_B     = seq_b_r;
  assign MATAB_MUX = mux_r;
  assign RES_ROW   = row_r;
  assign RES_COL   = col_r;
  assign RES_VALID = valid_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_simd_matmul_seq.sv
// Bench for simd_matmul_seq: a FETCH_LAT=1 instance on a combinational
// register file and a FETCH_LAT=2 instance on a one-cycle registered one.
module tb_simd_matmul_seq;
  import simd_pkg::*;

  localparam int N = 16;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic rst1, rst2, start_s, rdy, use2;
  logic start1, start2;
  row_t a_m [N];
  row_t b_m [N];
  logic [N-1:0][31:0] mat1, mat2;

  logic [3:0]  sa1, sb1, r1, c1, sa2, sb2, r2, c2;
  logic [31:0] d1, d2;
  logic        mux1, v1, busy1, done1, mux2, v2, busy2, done2;

  assign start1 = start_s & ~use2;
  assign start2 = start_s & use2;
  assign mat1   = mux1 ? a_m[sa1] : b_m[sb1];
  always @(posedge CLK) mat2 <= mux2 ? a_m[sa2] : b_m[sb2];

  simd_matmul_seq #(.N(N), .FETCH_LAT(1)) dut1 (
    .CLK(CLK), .RSTN(rst1), .START(start1), .MAT_IN(mat1),
    .SEQ_A(sa1), .SEQ_B(sb1), .MATAB_MUX(mux1), .RES_DATA(d1),
    .RES_ROW(r1), .RES_COL(c1), .RES_VALID(v1), .RES_READY(rdy),
    .BUSY(busy1), .DONE(done1));

  simd_matmul_seq #(.N(N), .FETCH_LAT(2)) dut2 (
    .CLK(CLK), .RSTN(rst2), .START(start2), .MAT_IN(mat2),
    .SEQ_A(sa2), .SEQ_B(sb2), .MATAB_MUX(mux2), .RES_DATA(d2),
    .RES_ROW(r2), .RES_COL(c2), .RES_VALID(v2), .RES_READY(rdy),
    .BUSY(busy2), .DONE(done2));

  logic [3:0]  o_sa, o_sb, o_row, o_col;
  logic [31:0] o_data;
  logic        o_mux, o_valid, o_busy, o_done;
  assign o_sa    = use2 ? sa2   : sa1;
  assign o_sb    = use2 ? sb2   : sb1;
  assign o_row   = use2 ? r2    : r1;
  assign o_col   = use2 ? c2    : c1;
  assign o_data  = use2 ? d2    : d1;
  assign o_mux   = use2 ? mux2  : mux1;
  assign o_valid = use2 ? v2    : v1;
  assign o_busy  = use2 ? busy2 : busy1;
  assign o_done  = use2 ? done2 : done1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_flags"}, {28'd0, o_valid, o_busy, o_done, o_mux}, 32'd0);
    chk({tag, "_sel"}, {24'd0, o_sa, o_sb}, 32'd0);
    chk({tag, "_idx"}, {24'd0, o_row, o_col}, 32'd0);
    chk({tag, "_data"}, o_data, 32'd0);
  endtask

  // C[i][j] = sum_k A[i][k] * Bt[j][k], wrapping at 32 bits.
  function automatic logic [31:0] ref_dot(input int i, input int j);
    logic [31:0] acc = 32'd0;
    for (int k = 0; k < N; k++) acc = acc + a_m[i][k] * b_m[j][k];
    return acc;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        case (mode)
          0: begin a_m[r][k] = 32'd5;          b_m[r][k] = 32'd3; end
          1: begin a_m[r][k] = (r == k) ? 32'd1 : 32'd0; b_m[r][k] = 32'(r + 1); end
          2: begin a_m[r][k] = 32'hFFFF_FFFF;  b_m[r][k] = 32'd1; end
          default: begin a_m[r][k] = $urandom; b_m[r][k] = $urandom; end
        endcase
      end
    end
  endtask

  // One full multiply; bp_i/bp_j < 0 disables the backpressure window.
  task automatic run(input int fl, input int bp_i, input int bp_j,
                     input bit rand_rdy, input bit mid_start);
    int  edges, n_res, n_done, hold, mux_cycles;
    bit  seen_valid, timed;
    timed = !rand_rdy && (bp_i < 0);
    edges = 0; n_res = 0; n_done = 0; hold = 0; mux_cycles = 0; seen_valid = 1'b0;
    rdy = 1'b1;
    start_s = 1'b1;
    @(posedge CLK); #1;
    start_s = 1'b0;
    while (n_done == 0 && edges < 4000) begin
      if (o_mux) mux_cycles++;
      if (o_valid && !seen_valid) begin
        seen_valid = 1'b1;
        if (timed) chk("first_valid_latency", 32'(edges), 32'(2 * fl + 2));
      end
      if (o_valid && int'(o_row) == bp_i && int'(o_col) == bp_j && hold < 7) begin
        rdy = 1'b0;
        chk("bp_data", o_data, ref_dot(bp_i, bp_j));
        chk("bp_idx", {24'd0, o_row, o_col}, 32'((bp_i << 4) | bp_j));
        chk("bp_sel", {23'd0, o_mux, o_sa, o_sb}, 32'((bp_i << 4) | bp_j));
        start_s = mid_start && (hold == 3);
        hold++;
      end else begin
        start_s = 1'b0;
        rdy = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (o_valid && rdy) begin
        chk("res_data", o_data, ref_dot(n_res / N, n_res % N));
        chk("res_idx", {24'd0, o_row, o_col}, 32'(n_res));
        chk("res_busy", {31'd0, o_busy}, 32'd1);
        n_res++;
      end
      if (o_done) begin
        n_done++;
        if (timed) chk("done_latency", 32'(edges), 32'(N * (fl + N * (fl + 3))));
      end
      @(posedge CLK); #1;
      edges++;
    end
    start_s = 1'b0;
    chk("done_seen", 32'(n_done), 32'd1);
    chk("result_count", 32'(n_res), 32'(N * N));
    chk("reqa_cycles", 32'(mux_cycles), 32'(N * fl));
    chk("after_done", {30'd0, o_done, o_busy}, 32'd0);
    if (bp_i >= 0) chk("bp_hold_cycles", 32'(hold), 32'd7);
  endtask

  initial begin
    int vcount;
    use2 = 1'b0; start_s = 1'b0; rdy = 1'b0; rst1 = 1'b1; rst2 = 1'b1;
    fill(0);
    repeat (5) begin
      @(posedge CLK); #1;
      chk_idle("reset");
    end
    rst1 = 1'b0;
    repeat (5) begin
      @(posedge CLK); #1;
      chk_idle("idle");
    end

    fill(0); run(1, -1, -1, 1'b0, 1'b0);
    fill(1); run(1, 2, 5, 1'b0, 1'b1);
    fill(2); run(1, -1, -1, 1'b0, 1'b0);
    fill(3); run(1, -1, -1, 1'b1, 1'b0);

    use2 = 1'b1;
    @(posedge CLK); #1;
    chk_idle("reset2");
    rst2 = 1'b0;
    @(posedge CLK); #1;
    run(2, -1, -1, 1'b0, 1'b0);

    // Abort during SUM (5 edges after the post-START sample with FETCH_LAT=2).
    start_s = 1'b1;
    @(posedge CLK); #1;
    start_s = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    rst2 = 1'b1;
    @(posedge CLK); #1;
    chk_idle("mid_reset");
    rst2 = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (o_valid || o_busy) vcount++;
    end
    chk("no_activity_after_reset", 32'(vcount), 32'd0);
    fill(3); run(2, -1, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simd_matmul_seq.md
Name: simd_matmul_seq

Overview:
- Sequencer and compute stage directly downstream of the A/B matrix register file.
- Drives the register file's row selects (SEQ_A, SEQ_B, MATAB_MUX) and captures the N-word row returned on MAT_IN.
- Computes C[i][j] = dot(A row i, B row j) for all N x N pairs and streams each result out with a valid/ready handshake.
- B is stored transposed in the register file: B row j is column j of the logical B matrix.

Parameters:
- N, 16, matrix dimension and SIMD lane count; power of two, >= 2.
- FETCH_LAT, 1, cycles the selects are held before MAT_IN is sampled; 1 = combinational register-file read; range 1..4.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTN  in  1  reset, synchronous, active-high (1 = reset).
- START  in  1  begin a full N x N multiply; sampled only in IDLE.
- MAT_IN  in  [N-1:0][31:0]  row data from the register file.
- SEQ_A  out  $clog2(N)  A row select.
- SEQ_B  out  $clog2(N)  B row select.
- MATAB_MUX  out  1  1 = select A region, 0 = select B region.
- RES_DATA  out  32  result C[i][j].
- RES_ROW  out  $clog2(N)  result index i.
- RES_COL  out  $clog2(N)  result index j.
- RES_VALID  out  1  result available.
- RES_READY  in  1  downstream accepts result.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse after the final result is accepted.

Behaviour:
- Reset: state IDLE, i = j = 0, all outputs 0, latched row A and row B cleared. Reset mid-operation aborts the run immediately; no further results are produced.
- State REQ_A: MATAB_MUX = 1, SEQ_A = i.
  - Held FETCH_LAT cycles; MAT_IN captured into rowA on the edge ending the last cycle.
  - Next state REQ_B.
- State REQ_B: MATAB_MUX = 0, SEQ_B = j.
  - Held FETCH_LAT cycles; captured into rowB the same way.
  - Next state MUL.
- State MUL: N lane products rowA[k]*rowB[k] registered, keeping the low 32 bits. Next state SUM.
- State SUM: adder tree over the N products registered into RES_DATA; all sums mod 2^32, so the result is identical for signed and unsigned operands. Next state OUT.
- State OUT: RES_VALID = 1, RES_ROW = i, RES_COL = j.
  - RES_DATA, RES_ROW and RES_COL are stable while RES_VALID = 1 and RES_READY = 0.
  - The handshake completes on an edge where RES_VALID and RES_READY are both 1.
  - On handshake:
    - j < N-1: j++, go to REQ_B (rowA reused, not refetched).
    - j = N-1 and i < N-1: j = 0, i++, go to REQ_A.
    - i = j = N-1: go to DONE.
- State DONE: DONE = 1 for exactly one cycle, i = j = 0, then IDLE.
- In IDLE, START = 1 moves to REQ_A next cycle. START is ignored in every other state.
- Select defaults:
  - SEQ_A and SEQ_B hold their last value outside their REQ state; they are 0 after reset.
  - MATAB_MUX = 0 except in REQ_A.
- Latency with FETCH_LAT = 1 and RES_READY = 1:
  - RES_VALID first rises 4 cycles after the cycle in which START is sampled.
  - Later results in the same row follow every 4 cycles; a row change costs 1 extra cycle.
  - A full run takes N*(1+4N) cycles, 1040 for N = 16, then the DONE cycle.
  - Each extra FETCH_LAT cycle adds 1 cycle per REQ state.

Decomposition:
- Shared package simd_pkg contains:
  - word_t (logic [31:0]) and row_t (word_t [N-1:0]);
  - state enum seq_state_e {IDLE, REQ_A, REQ_B, MUL, SUM, OUT, DONE};
  - DATA_W = 32.
- One sub-module, simd_dot_n: parameter N; registered multiply stage plus registered adder-tree stage; enable per stage. The FSM, fetch counter and i/j counters stay in the top.

Test Plan:
- Reset, then idle with RSTN = 0 for 5 cycles: all outputs 0, BUSY = 0, selects never change.
- A all 5, B all 3, RES_READY = 1, START pulse: 256 results, each 240, order (0,0),(0,1)...(15,15); first RES_VALID 4 cycles after START; DONE pulses once, 1040 cycles after START.
- A = identity, B row j = {j+1 repeated}: C[i][j] = j+1 for all i, confirming rowA reuse across j and the refetch at each i.
- Overflow: A all 0xFFFF_FFFF, B all 1: every result 0xFFFF_FFF0.
- Backpressure: RES_READY held 0 for 7 cycles at result (2,5): RES_VALID, data and indices stable, no select activity; resumes correctly on release. A START pulse mid-run is ignored.
- FETCH_LAT = 2 build: each REQ state lasts 2 cycles, MAT_IN sampled on the second edge, results match the FETCH_LAT = 1 run. RSTN = 1 asserted during SUM: next cycle IDLE with all outputs 0, and a fresh START restarts at (0,0).
